i2s_tx_seq: RTL
===============

// Module: i2s_tx_seq
// PURPOSE
//  Master-mode I2S (Philips) transmit sequencer. Derives sclk from pclk with a runtime divisor and drives ws and sd.
//  Accepts one stereo pair per frame over a valid/ready handshake from the sample source.
//  Sits between the TX sample buffer and the I2S pins. Ctrl regs supply div_n/frame32/en.
// PARAMETERS
//  DATA_W   32  sample width; slot data is left-justified, MSB = bit DATA_W-1
//  DIV_W    6   width of div_n
// PORTS
//  pclk      in   1       system clock; all logic on posedge pclk
//  rst_      in   1       reset, asynchronous, active-low
//  en        in   1       run request
//  div_n     in   DIV_W   sclk period in pclk cycles; values <2 treated as 2
//  frame32   in   1       1: 32-bit slots (64 sclk/frame); 0: 16-bit slots (32 sclk/frame)
//  tx_valid  in   1       pair available
//  tx_left   in   DATA_W  left sample
//  tx_right  in   DATA_W  right sample
//  tx_ready  out  1       = !hold_full; transfer when tx_valid && tx_ready
//  sclk      out  1       serial bit clock (registered)
//  ws        out  1       word select: 0 = left, 1 = right
//  sd        out  1       serial data, MSB first
//  busy      out  1       state != IDLE
//  underrun  out  1       1-pclk pulse at a frame start with no pair held
// BEHAVIOUR
//  Reset: state=IDLE, sclk=0, ws=1, sd=0, busy=0, underrun=0, tx_ready=1, hold/shift regs and last_bit cleared.
//  Reset is valid mid-frame: outputs return to reset values at once; held pair is discarded.
//  Divider: cnt runs 0..N-1. sclk=0 for cnt<ceil(N/2), else 1.
//   N=4: 2 low/2 high. N=5: 3 low/2 high.
//   Falling tick = the pclk edge where cnt wraps to 0. ws/sd change only on falling ticks.
//  div_n and frame32 are latched on the IDLE->RUN edge. Changes while busy are ignored.
//  Hold buffer: one pair deep. Accepts whenever empty, in any state.
//  FSM IDLE/RUN/TAIL:
//   IDLE: sclk=0, ws=1, sd=0.
//    en=1 -> RUN on the next edge. That edge is frame start with cnt=0.
//   RUN: S=16|32. Period p=0..2S-1 counted in falling ticks.
//    ws=0 for p<S, ws=1 for p>=S.
//    sd (one-bit I2S delay):
//     p=0        : last_bit (previous frame's right LSB; 0 on the first frame)
//     p=1..S     : left bits DATA_W-1 downward
//     p=S+1..2S-1: right bits DATA_W-1 downward
//    Right LSB is saved to last_bit.
//   Frame start (entry to RUN, or tick after p=2S-1 with en=1):
//    If hold_full: move the pair to the shift regs and clear hold_full.
//    Else: underrun pulse, load zeros.
//   Same-edge case: tx_valid arriving with hold empty on the frame-start edge fills hold for the NEXT frame.
//    The current frame still underruns; there is no bypass.
//   en=0: the current frame completes. At the tick after p=2S-1, go to TAIL with no load.
//   TAIL: one sclk period with ws=0, sd=last_bit. Then IDLE, with ws=1, sd=0, sclk=0.
//   en re-asserted during TAIL is ignored until IDLE.
//  Bit selection in 16-bit mode sends bits DATA_W-1..DATA_W-16 of each sample.
// CONFIGURATION
//  UNDERRUN_REPEAT_EN defined:
//   On underrun, the shift regs reload the last transmitted pair (zeros if none since reset).
//   The underrun pulse is unchanged.
//  Not defined: on underrun, zeros are loaded.
// TESTING
//  1. N=4, frame32=1, pair L=32'h8000_0001, R=32'hFFFF_0000, en=1:
//     sclk period 4 pclk, 2 low/2 high. ws low 128 pclk then high 128.
//     sd: p1=1, p2..p31=0, p32=1, p33..p48=1, p49..p63=0. Next frame p0=0.
//  2. N=5, frame32=0: sclk 3 low/2 high, ws toggles every 80 pclk.
//     L=32'hA5A5_xxxx is sent as 1010010110100101 in p1..p16.
//  3. No tx_valid after the first pair: underrun pulses once per frame start.
//     sd is all zeros. With UNDERRUN_REPEAT_EN, the first pair repeats.
//  4. en=0 at p=10 of a frame:
//     frame completes, one TAIL period carries right LSB with ws=0, then busy=0, ws=1. No tx_ready-consumed load.
//  5. rst_ low at p=20: sclk/ws/sd/busy go to 0/1/0/0 at once.
//     After release with en=1, the first frame sd p0=0 and the hold is empty, so underrun pulses.
//  6. div_n=0 and div_n=1 behave as N=2. Changing div_n mid-run leaves the sclk period unchanged until re-entry from IDLE.

Source files
------------

// File: rtl/i2s_tx_seq.sv
// i2s_tx_seq: master-mode Philips I2S transmit sequencer.
// The block divides pclk down to sclk using a runtime divisor, and drives ws and sd.
// It accepts one stereo pair per frame through a one-deep hold buffer.
// Optional feature macro: UNDERRUN_REPEAT_EN. When it is defined, an underrun frame
// repeats the last transmitted pair instead of sending zeros.
module i2s_tx_seq #(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 6
) (
  input  logic              pclk,
  input  logic              rst_,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_n,
  input  logic              frame32,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_left,
  input  logic [DATA_W-1:0] tx_right,
  output logic              tx_ready,
  output logic              sclk,
  output logic              ws,
  output logic              sd,
  output logic              busy,
  output logic              underrun
);

  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

  // Clamp the divisor: sclk needs at least one low and one high pclk.
  function automatic logic [DIV_W-1:0] sat_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  // Number of low pclk cycles in one sclk period: ceil(N/2).
  function automatic logic [DIV_W:0] half_period(input logic [DIV_W-1:0] n);
    logic [DIV_W:0] t;
    t = {1'b0, n} + {{DIV_W{1'b0}}, 1'b1};
    return t >> 1;
  endfunction

  // Bits per slot.
  function automatic logic [6:0] slot_bits(input logic wide);
    return wide ? 7'd32 : 7'd16;
  endfunction

  state_t              state, state_nx;
  logic [DIV_W-1:0]    cnt, cnt_nx, cnt_step;
  logic [DIV_W-1:0]    n_lat, n_lat_nx;
  logic                s32, s32_nx;
  logic [5:0]          p, p_nx, last_p;
  logic [6:0]          p_inc, s_val;
  logic                tick, frame_start;
  logic                sclk_nx, ws_nx, sd_nx, und_nx;
  logic                last_bit, last_bit_nx;
  logic                hold_full, hold_full_nx;
  logic [DATA_W-1:0]   hold_l, hold_l_nx, hold_r, hold_r_nx;
  logic [DATA_W-1:0]   sh_l, sh_l_nx, sh_r, sh_r_nx;
`ifdef UNDERRUN_REPEAT_EN
  logic [DATA_W-1:0]   rep_l, rep_l_nx, rep_r, rep_r_nx;
`endif

  assign tx_ready = !hold_full;
  assign busy     = (state != IDLE);

  assign tick     = (cnt == n_lat - 1'b1);
  assign cnt_step = tick ? '0 : cnt + 1'b1;
  assign last_p   = s32 ? 6'd63 : 6'd31;
  assign p_inc    = {1'b0, p} + 7'd1;
  assign s_val    = slot_bits(s32);

  // Next-state logic: divider, frame position, serial outputs, hold/shift handling.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    n_lat_nx     = n_lat;
    s32_nx       = s32;
    p_nx         = p;
    sclk_nx      = 1'b0;
    ws_nx        = ws;
    sd_nx        = sd;
    und_nx       = 1'b0;
    last_bit_nx  = last_bit;
    hold_full_nx = hold_full;
    hold_l_nx    = hold_l;
    hold_r_nx    = hold_r;
    sh_l_nx      = sh_l;
    sh_r_nx      = sh_r;
`ifdef UNDERRUN_REPEAT_EN
    rep_l_nx     = rep_l;
    rep_r_nx     = rep_r;
`endif
    frame_start  = 1'b0;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        ws_nx  = 1'b1;
        sd_nx  = 1'b0;
        if (en) begin
          state_nx    = RUN;
          n_lat_nx    = sat_div(div_n);
          s32_nx      = frame32;
          sd_nx       = last_bit;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        cnt_nx  = cnt_step;
        sclk_nx = ({1'b0, cnt_step} >= half_period(n_lat));
        if (tick) begin
          if (p == last_p) begin
            // The final right-slot bit goes out in the next frame's p=0, or in the tail.
            sd_nx       = sh_r[DATA_W-1];
            last_bit_nx = sh_r[DATA_W-1];
            ws_nx       = 1'b0;
            p_nx        = '0;
            if (en) frame_start = 1'b1;
            else    state_nx    = TAIL;
          end else begin
            p_nx  = p + 6'd1;
            ws_nx = (p_inc >= s_val);
            if (p_inc <= s_val) begin
              sd_nx   = sh_l[DATA_W-1];
              sh_l_nx = {sh_l[DATA_W-2:0], 1'b0};
            end else begin
              sd_nx   = sh_r[DATA_W-1];
              sh_r_nx = {sh_r[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      TAIL: begin
        cnt_nx  = cnt_step;
        sclk_nx = ({1'b0, cnt_step} >= half_period(n_lat));
        if (tick) begin
          state_nx = IDLE;
          ws_nx    = 1'b1;
          sd_nx    = 1'b0;
          sclk_nx  = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase

    // A frame start consumes the held pair. A pair arriving on that same edge waits for the next frame.
    if (frame_start && hold_full) begin
      ws_nx        = 1'b0;
      p_nx         = '0;
      sh_l_nx      = hold_l;
      sh_r_nx      = hold_r;
      hold_full_nx = 1'b0;
`ifdef UNDERRUN_REPEAT_EN
      rep_l_nx     = hold_l;
      rep_r_nx     = hold_r;
`endif
    end else begin
      if (frame_start) begin
        ws_nx  = 1'b0;
        p_nx   = '0;
        und_nx = 1'b1;
`ifdef UNDERRUN_REPEAT_EN
        sh_l_nx = rep_l;
        sh_r_nx = rep_r;
`else
        sh_l_nx = '0;
        sh_r_nx = '0;
`endif
      end
      if (!hold_full && tx_valid) begin
        hold_full_nx = 1'b1;
        hold_l_nx    = tx_left;
        hold_r_nx    = tx_right;
      end
    end
  end

  // Control and pin registers.
  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      cnt       <= '0;
      n_lat     <= '0;
      s32       <= 1'b0;
      p         <= '0;
      sclk      <= 1'b0;
      ws        <= 1'b1;
      sd        <= 1'b0;
      underrun  <= 1'b0;
      last_bit  <= 1'b0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      n_lat     <= n_lat_nx;
      s32       <= s32_nx;
      p         <= p_nx;
      sclk      <= sclk_nx;
      ws        <= ws_nx;
      sd        <= sd_nx;
      underrun  <= und_nx;
      last_bit  <= last_bit_nx;
      hold_full <= hold_full_nx;
    end
  end

  // Sample registers: hold buffer and per-slot shift registers.
  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      hold_l <= '0;
      hold_r <= '0;
      sh_l   <= '0;
      sh_r   <= '0;
    end else begin
      hold_l <= hold_l_nx;
      hold_r <= hold_r_nx;
      sh_l   <= sh_l_nx;
      sh_r   <= sh_r_nx;
    end
  end

`ifdef UNDERRUN_REPEAT_EN
  // Last pair loaded from the hold buffer; it is replayed on underrun.
  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      rep_l <= '0;
      rep_r <= '0;
    end else begin
      rep_l <= rep_l_nx;
      rep_r <= rep_r_nx;
    end
  end
`endif

endmodule
